video_cfg_ctrl: RTL and testbench

AXI-Lite configuration controller for the video enhancement pipeline. It decodes the one-hot internal address space (ENABLES, BRIGHTNESS, CONTRAST, GAMMA_LUT) and holds the staged and active copies of the per-stage controls. Staged values are committed to the datapath only on a start-of-frame pulse, so no frame is processed with mixed settings. It also forwards gamma LUT accesses to the external LUT memory.

---
 rtl/video_cfg_ctrl_pkg.sv | 58 +++++
 rtl/video_cfg_ctrl_if.sv | 32 +++
 rtl/video_cfg_ctrl_axil_addr_decode.sv | 27 ++
 rtl/video_cfg_ctrl.sv | 175 +++++++++++++++++
 tb/tb_video_cfg_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_cfg_ctrl_pkg.sv
// Shared types, address map and FSM encodings for the video configuration controller.
package video_cfg_ctrl_pkg;

    localparam int PADDR = 16;
    localparam int PDATA = 16;
    localparam int PRESP = 2;

    typedef logic [7:0]        color_t;
    typedef logic signed [8:0] color_signed_t;
    typedef logic [7:0]        contrast_fp_t;   // unsigned Q2.6

    localparam contrast_fp_t CONTRAST_ONE = 8'h40;

    localparam logic [3:0] ADDR_ENABLES    = 4'h1;
    localparam logic [3:0] ADDR_BRIGHTNESS = 4'h2;
    localparam logic [3:0] ADDR_CONTRAST   = 4'h4;
    localparam logic [3:0] ADDR_GAMMA_LUT  = 4'h8;

    localparam logic [PRESP-1:0] RESP_OKAY   = 2'b00;
    localparam logic [PRESP-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        REG_ENABLES,
        REG_BRIGHTNESS,
        REG_CONTRAST,
        REG_GAMMA_LUT
    } region_e;

    typedef struct packed {
        logic [2:0]    enables;
        color_signed_t brightness;
        contrast_fp_t  contrast;
    } cfg_regs_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rstate_e;

    function automatic logic [PDATA-1:0] reg_rdata(input cfg_regs_t c, input region_e r);
        logic [PDATA-1:0] d;
        d = '0;
        case (r)
            REG_ENABLES:    d = {13'd0, c.enables};
            REG_BRIGHTNESS: d = {{7{c.brightness[8]}}, c.brightness};
            REG_CONTRAST:   d = {8'd0, c.contrast};
            default:        d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/video_cfg_ctrl_if.sv
// AXI-Lite configuration bus between a host (master) and the controller (slave).
interface video_cfg_ctrl_if;
    import video_cfg_ctrl_pkg::*;

    logic             awvalid;
    logic             awready;
    logic [PADDR-1:0] awaddr;
    logic             wvalid;
    logic             wready;
    logic [PDATA-1:0] wdata;
    logic             bvalid;
    logic             bready;
    logic [PRESP-1:0] bresp;
    logic             arvalid;
    logic             arready;
    logic [PADDR-1:0] araddr;
    logic             rvalid;
    logic             rready;
    logic [PDATA-1:0] rdata;
    logic [PRESP-1:0] rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/video_cfg_ctrl_axil_addr_decode.sv
// Combinational decode of a bus address into register region and LUT index.
module axil_addr_decode
    import video_cfg_ctrl_pkg::*;
(
    input  logic [PADDR-1:0] paddr,
    output region_e          region,
    output color_t           lut_idx,
    output logic             valid
);

    logic unused_mid;
    assign unused_mid = ^paddr[11:8];
    assign lut_idx    = paddr[7:0];

    always_comb begin
        region = REG_ENABLES;
        valid  = 1'b1;
        case (paddr[15:12])
            ADDR_ENABLES:    region = REG_ENABLES;
            ADDR_BRIGHTNESS: region = REG_BRIGHTNESS;
            ADDR_CONTRAST:   region = REG_CONTRAST;
            ADDR_GAMMA_LUT:  region = REG_GAMMA_LUT;
            default:         valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/video_cfg_ctrl.sv
// Video pipeline configuration controller: AXI-Lite register file, frame-synchronous commit, gamma LUT forwarding.
// Define VIDEO_CFG_CTRL_SHADOW_EN for staged/active double buffering committed on sof.
//
// state  | meaning
// W_IDLE | waiting for aw+w together; accept, update staged or strobe LUT
// W_RESP | bvalid high until bready
// R_IDLE | waiting for ar; registers go to R_RESP, LUT reads to R_WAIT
// R_WAIT | capturing lut_rdata one cycle after lut_re
// R_RESP | rvalid high until rready
module video_cfg_ctrl
    import video_cfg_ctrl_pkg::*;
#(
    parameter contrast_fp_t CONTRAST_RST = CONTRAST_ONE
) (
    input  logic             clk,
    input  logic             rst,
    video_cfg_ctrl_if.slave  axil,
    input  logic             sof,
    output logic [2:0]       enables_o,
    output color_signed_t    brightness_o,
    output contrast_fp_t     contrast_o,
    output logic             cfg_pending_o,
    output logic             lut_we,
    output logic             lut_re,
    output color_t           lut_addr,
    output color_t           lut_wdata,
    input  color_t           lut_rdata
);

    localparam cfg_regs_t CFG_RST = '{enables: 3'b000, brightness: 9'sd0, contrast: CONTRAST_RST};

    region_e          w_region, r_region;
    color_t           w_idx, r_idx;
    logic             w_valid, r_valid;
    wstate_e          w_state;
    rstate_e          r_state;
    cfg_regs_t        staged, staged_nxt, active;
    logic             pending;
    logic             w_accept, w_lut, w_reg, lut_wr_ok, r_conflict, r_accept;
    logic [PRESP-1:0] bresp_q, rresp_q;
    logic [PDATA-1:0] rdata_q;
    logic             unused_wdata;

    axil_addr_decode u_wdec (
        .paddr   (axil.awaddr),
        .region  (w_region),
        .lut_idx (w_idx),
        .valid   (w_valid)
    );

    axil_addr_decode u_rdec (
        .paddr   (axil.araddr),
        .region  (r_region),
        .lut_idx (r_idx),
        .valid   (r_valid)
    );

    assign unused_wdata = ^axil.wdata[15:9];

    always_comb begin
        w_accept   = (w_state == W_IDLE) & axil.awvalid & axil.wvalid;
        w_lut      = w_accept & w_valid & (w_region == REG_GAMMA_LUT);
        w_reg      = w_accept & w_valid & (w_region != REG_GAMMA_LUT);
        // LUT contents must not change under a frame that is using them
        lut_wr_ok  = w_lut & ~active.enables[2];
        r_conflict = w_lut & r_valid & (r_region == REG_GAMMA_LUT);
        r_accept   = (r_state == R_IDLE) & axil.arvalid & ~r_conflict;
    end

    assign axil.awready = w_accept;
    assign axil.wready  = w_accept;
    assign axil.bvalid  = (w_state == W_RESP);
    assign axil.bresp   = bresp_q;
    assign axil.arready = r_accept;
    assign axil.rvalid  = (r_state == R_RESP);
    assign axil.rdata   = rdata_q;
    assign axil.rresp   = rresp_q;

    assign lut_we    = lut_wr_ok;
    assign lut_re    = r_accept & r_valid & (r_region == REG_GAMMA_LUT);
    assign lut_addr  = lut_wr_ok ? w_idx : r_idx;
    assign lut_wdata = axil.wdata[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            bresp_q <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: if (w_accept) begin
                    bresp_q <= (w_reg | lut_wr_ok) ? RESP_OKAY : RESP_SLVERR;
                    w_state <= W_RESP;
                end
                W_RESP: if (axil.bready) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            rresp_q <= RESP_OKAY;
            rdata_q <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (r_accept) begin
                    if (!r_valid) begin
                        rdata_q <= '0;
                        rresp_q <= RESP_SLVERR;
                        r_state <= R_RESP;
                    end else if (r_region == REG_GAMMA_LUT) begin
                        rresp_q <= RESP_OKAY;
                        r_state <= R_WAIT;
                    end else begin
                        rdata_q <= reg_rdata(staged, r_region);
                        rresp_q <= RESP_OKAY;
                        r_state <= R_RESP;
                    end
                end
                R_WAIT: begin
                    rdata_q <= {8'd0, lut_rdata};
                    r_state <= R_RESP;
                end
                R_RESP: if (axil.rready) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        staged_nxt = staged;
        if (w_reg) begin
            case (w_region)
                REG_ENABLES:    staged_nxt.enables    = axil.wdata[2:0];
                REG_BRIGHTNESS: staged_nxt.brightness = axil.wdata[8:0];
                REG_CONTRAST:   staged_nxt.contrast   = axil.wdata[7:0];
                default:        staged_nxt = staged;
            endcase
        end
    end

`ifdef VIDEO_CFG_CTRL_SHADOW_EN
    // active copies the pre-write staged value, so a write in the sof cycle waits for the next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            staged  <= CFG_RST;
            active  <= CFG_RST;
            pending <= 1'b0;
        end else begin
            staged <= staged_nxt;
            if (sof && pending) active <= staged;
            if (w_reg) pending <= 1'b1;
            else if (sof) pending <= 1'b0;
        end
    end
`else
    logic unused_sof;
    assign unused_sof = sof;

    always_ff @(posedge clk) begin
        if (rst) staged <= CFG_RST;
        else     staged <= staged_nxt;
    end

    assign active  = staged;
    assign pending = 1'b0;
`endif

    assign enables_o     = active.enables;
    assign brightness_o  = active.brightness;
    assign contrast_o    = active.contrast;
    assign cfg_pending_o = pending;

endmodule

// File: tb/tb_video_cfg_ctrl.sv
// Scoreboard bench for video_cfg_ctrl: directed AXI-Lite traffic, response queues checked by a monitor.
module tb_video_cfg_ctrl;
    import video_cfg_ctrl_pkg::*;

`ifdef VIDEO_CFG_CTRL_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sof = 1'b0;
    logic [2:0]    enables_o;
    color_signed_t brightness_o;
    contrast_fp_t  contrast_o;
    logic          cfg_pending_o;
    logic          lut_we, lut_re;
    color_t        lut_addr, lut_wdata, lut_rdata;
    color_t        mem [256];

    logic [1:0]  bq[$];
    logic [17:0] rq[$];
    int n_cmp = 0;
    int n_bad = 0;

    video_cfg_ctrl_if bus();

    video_cfg_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .axil          (bus),
        .sof           (sof),
        .enables_o     (enables_o),
        .brightness_o  (brightness_o),
        .contrast_o    (contrast_o),
        .cfg_pending_o (cfg_pending_o),
        .lut_we        (lut_we),
        .lut_re        (lut_re),
        .lut_addr      (lut_addr),
        .lut_wdata     (lut_wdata),
        .lut_rdata     (lut_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lut_we) mem[lut_addr] <= lut_wdata;
        if (lut_re) lut_rdata <= mem[lut_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.bvalid && bus.bready) begin
            if (bq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL bresp_unexpected: got bvalid with empty queue, expected none");
            end else chk("bresp", bus.bresp, bq.pop_front());
        end
        if (bus.rvalid && bus.rready) begin
            if (rq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rresp_unexpected: got rvalid with empty queue, expected none");
            end else begin
                logic [17:0] e;
                e = rq.pop_front();
                chk("rresp", bus.rresp, e[17:16]);
                chk("rdata", bus.rdata, e[15:0]);
            end
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic wait_b(input string nm);
        int n = 0;
        @(negedge clk);
        while (!bus.bvalid && n < 20) begin n++; @(negedge clk); end
        chk({nm, "_b_lat"}, n, 0);
        sync();
    endtask

    task automatic wait_r(input string nm, input int lat);
        int n = 1;
        @(negedge clk);
        while (!bus.rvalid && n < 20) begin n++; @(negedge clk); end
        chk({nm, "_r_lat"}, n, lat);
        sync();
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] resp,
                      input logic exp_we, input string nm);
        int n = 0;
        bq.push_back(resp);
        bus.awaddr = a; bus.wdata = d; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        while (!bus.awready && n < 20) begin n++; @(negedge clk); end
        chk({nm, "_aw_wait"}, n < 20, 1);
        chk({nm, "_lut_we"}, lut_we, exp_we);
        sync();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        wait_b(nm);
    endtask

    task automatic rd(input logic [15:0] a, input logic [1:0] resp, input logic [15:0] d,
                      input int lat, input string nm);
        int n = 0;
        rq.push_back({resp, d});
        bus.araddr = a; bus.arvalid = 1'b1;
        @(negedge clk);
        while (!bus.arready && n < 20) begin n++; @(negedge clk); end
        chk({nm, "_ar_wait"}, n < 20, 1);
        chk({nm, "_lut_re"}, lut_re, lat == 2);
        sync();
        bus.arvalid = 1'b0;
        wait_r(nm, lat);
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        sync();
        sof = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        int n;
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        bus.awaddr = '0; bus.wdata = '0; bus.araddr = '0;
        bus.bready = 1; bus.rready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_enables", enables_o, 0);
        chk("rst_bright", {23'd0, brightness_o}, 0);
        chk("rst_contrast", contrast_o, 8'h40);
        chk("rst_pending", cfg_pending_o, 0);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_lut_strobes", {lut_we, lut_re}, 0);
        sync();
        rd(16'h4000, OK, 16'h0040, 1, "rd_contrast_rst");

        // staged brightness write, committed by sof
        wr(16'h2000, 16'h01F6, OK, 0, "wr_bright");
        rd(16'h2000, OK, 16'hFFF6, 1, "rd_bright");
        @(negedge clk);
        chk("bright_before_sof", {23'd0, brightness_o}, SHADOW ? 32'h0 : 32'h1F6);
        chk("pending_before_sof", cfg_pending_o, SHADOW);
        sync();
        pulse_sof();
        @(negedge clk);
        chk("bright_after_sof", {23'd0, brightness_o}, 32'h1F6);
        chk("pending_after_sof", cfg_pending_o, 0);
        sync();

        wr(16'h8010, 16'h00AB, OK, 1, "wr_lut");
        rd(16'h8010, OK, 16'h00AB, 2, "rd_lut");

        // gamma active blocks LUT writes, reads still allowed
        wr(16'h1000, 16'h0004, OK, 0, "wr_en");
        pulse_sof();
        @(negedge clk);
        chk("enables_gamma", enables_o, 3'b100);
        sync();
        wr(16'h8011, 16'h0055, ERR, 0, "wr_lut_gamma");
        rd(16'h8010, OK, 16'h00AB, 2, "rd_lut_gamma");

        wr(16'h3000, 16'h1234, ERR, 0, "wr_bad");
        rd(16'h0000, ERR, 16'h0000, 1, "rd_bad");
        rd(16'h1000, OK, 16'h0004, 1, "rd_en_after_bad");
        wr(16'h1000, 16'h0000, OK, 0, "wr_en_off");
        pulse_sof();

        // write accepted in the sof cycle lands after the copy
        wr(16'h2000, 16'h0005, OK, 0, "wr_bright5");
        bq.push_back(OK);
        bus.awaddr = 16'h4000; bus.wdata = 16'h0080; bus.awvalid = 1; bus.wvalid = 1;
        sof = 1'b1;
        @(negedge clk);
        chk("sof_wr_awready", bus.awready, 1);
        sync();
        bus.awvalid = 0; bus.wvalid = 0; sof = 1'b0;
        @(negedge clk);
        chk("sof_wr_contrast", contrast_o, SHADOW ? 8'h40 : 8'h80);
        chk("sof_wr_bright", {23'd0, brightness_o}, 32'h005);
        chk("sof_wr_pending", cfg_pending_o, SHADOW);
        sync();
        pulse_sof();
        @(negedge clk);
        chk("next_sof_contrast", contrast_o, 8'h80);
        chk("next_sof_pending", cfg_pending_o, 0);
        sync();

        // simultaneous LUT write and LUT read: write wins
        bq.push_back(OK);
        rq.push_back({OK, 16'h00AB});
        bus.awaddr = 16'h8012; bus.wdata = 16'h0033; bus.awvalid = 1; bus.wvalid = 1;
        bus.araddr = 16'h8010; bus.arvalid = 1;
        @(negedge clk);
        chk("conc_awready", bus.awready, 1);
        chk("conc_arready", bus.arready, 0);
        chk("conc_strobes", {lut_we, lut_re}, 2'b10);
        sync();
        bus.awvalid = 0; bus.wvalid = 0;
        n = 0;
        @(negedge clk);
        while (!bus.arready && n < 20) begin n++; @(negedge clk); end
        chk("conc_ar_late", n, 0);
        chk("conc_lut_re", lut_re, 1);
        sync();
        bus.arvalid = 0;
        wait_r("rd_conc", 2);
        rd(16'h8012, OK, 16'h0033, 2, "rd_lut_conc");

        // reset while a write response is outstanding
        bus.bready = 0;
        bq.push_back(OK);
        bus.awaddr = 16'h2000; bus.wdata = 16'h0007; bus.awvalid = 1; bus.wvalid = 1;
        @(negedge clk);
        chk("rstw_awready", bus.awready, 1);
        sync();
        bus.awvalid = 0; bus.wvalid = 0;
        @(negedge clk);
        chk("rstw_bvalid_held", bus.bvalid, 1);
        sync();
        rst = 1'b1;
        sync();
        @(negedge clk);
        chk("rstw_bvalid", bus.bvalid, 0);
        chk("rstw_bright", {23'd0, brightness_o}, 0);
        chk("rstw_contrast", contrast_o, 8'h40);
        chk("rstw_enables", enables_o, 0);
        chk("rstw_pending", cfg_pending_o, 0);
        sync();
        rst = 1'b0;
        bus.bready = 1;
        bq.delete();
        rd(16'h2000, OK, 16'h0000, 1, "rd_bright_rst");
        rd(16'h4000, OK, 16'h0040, 1, "rd_contrast_rst2");

        repeat (3) sync();
        chk("bq_empty", bq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
